// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens, symbol/disparity types and ones counter
package tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    typedef logic [9:0]        tmds_sym_t;
    typedef logic signed [4:0] tmds_disp_t;

    function automatic logic [3:0] count_ones8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder_ch.sv
// rtl/tmds_encoder_ch.sv - one TMDS channel: transition-minimising stage then DC-balancing stage
module tmds_encoder_ch
    import tmds_pkg::*;
(
    input  logic       clk_pix,
    input  logic       rstn_i,
    input  logic       de,
    input  logic [1:0] ctrl,
    input  logic [7:0] din,
    output logic [9:0] dout
);

    logic [3:0] n1_din;
    logic       use_xnor;
    logic [8:0] qm_c;
    logic [3:0] n1_qm_c;

    always_comb begin
        n1_din   = count_ones8(din);
        use_xnor = (n1_din > 4'd4) || ((n1_din == 4'd4) && !din[0]);
        qm_c     = '0;
        qm_c[0]  = din[0];
        for (int i = 1; i < 8; i++) begin
            qm_c[i] = use_xnor ? ~(qm_c[i-1] ^ din[i]) : (qm_c[i-1] ^ din[i]);
        end
        qm_c[8]  = ~use_xnor;
        n1_qm_c  = count_ones8(qm_c[7:0]);
    end

    logic [8:0] s1_qm;
    logic [3:0] s1_n1;
    logic [3:0] s1_n0;
    logic       s1_de;
    logic [1:0] s1_ctrl;

    always_ff @(posedge clk_pix) begin
        if (!rstn_i) begin
            s1_qm   <= '0;
            s1_n1   <= '0;
            s1_n0   <= '0;
            s1_de   <= 1'b0;
            s1_ctrl <= 2'b00;
        end else begin
            s1_qm   <= qm_c;
            s1_n1   <= n1_qm_c;
            s1_n0   <= 4'd8 - n1_qm_c;
            s1_de   <= de;
            s1_ctrl <= ctrl;
        end
    end

    tmds_disp_t        cnt_r;
    tmds_sym_t         dout_r;
    tmds_sym_t         sym_next;
    logic signed [5:0] cnt_ext;
    logic signed [5:0] diff;
    logic signed [5:0] cnt_next6;

    // Arithmetic is carried at 6 bits so the intermediate sums cannot wrap before truncation.
    always_comb begin
        cnt_ext   = {cnt_r[4], cnt_r};
        diff      = $signed({2'b00, s1_n1}) - $signed({2'b00, s1_n0});
        sym_next  = TMDS_CTRL_00;
        cnt_next6 = '0;
        if (!s1_de) begin
            case (s1_ctrl)
                2'b00:   sym_next = TMDS_CTRL_00;
                2'b01:   sym_next = TMDS_CTRL_01;
                2'b10:   sym_next = TMDS_CTRL_10;
                default: sym_next = TMDS_CTRL_11;
            endcase
            cnt_next6 = '0;
        end else if ((cnt_r == 5'sd0) || (s1_n1 == s1_n0)) begin
            sym_next  = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
            cnt_next6 = s1_qm[8] ? (cnt_ext + diff) : (cnt_ext - diff);
        end else if ((!cnt_r[4] && (s1_n1 > s1_n0)) || (cnt_r[4] && (s1_n0 > s1_n1))) begin
            sym_next  = {1'b1, s1_qm[8], ~s1_qm[7:0]};
            cnt_next6 = cnt_ext + $signed({4'b0000, s1_qm[8], 1'b0}) - diff;
        end else begin
            sym_next  = {1'b0, s1_qm[8], s1_qm[7:0]};
            cnt_next6 = cnt_ext + diff - $signed({4'b0000, ~s1_qm[8], 1'b0});
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rstn_i) begin
            cnt_r  <= '0;
            dout_r <= TMDS_CTRL_00;
        end else begin
            cnt_r  <= cnt_next6[4:0];
            dout_r <= sym_next;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/tmds_encode_rgb.sv
// rtl/tmds_encode_rgb.sv - three-channel DVI TMDS encoder with optional output register
module tmds_encode_rgb
    import tmds_pkg::*;
#(
    parameter int OUT_REG  = 1,
    parameter int SYNC_INV = 0
) (
    input  logic       clk_pix,
    input  logic       rstn_i,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic [9:0] tmds_ch0,
    output logic [9:0] tmds_ch1,
    output logic [9:0] tmds_ch2
);

    localparam logic SINV = (SYNC_INV != 0);

    logic [1:0] ctrl_blue;
    tmds_sym_t  enc0;
    tmds_sym_t  enc1;
    tmds_sym_t  enc2;

    // Only the blue lane carries sync; green and red always send control 00 in blanking.
    assign ctrl_blue = {vsync ^ SINV, hsync ^ SINV};

    tmds_encoder_ch u_ch0 (
        .clk_pix (clk_pix),
        .rstn_i  (rstn_i),
        .de      (de),
        .ctrl    (ctrl_blue),
        .din     (pix_b),
        .dout    (enc0)
    );

    tmds_encoder_ch u_ch1 (
        .clk_pix (clk_pix),
        .rstn_i  (rstn_i),
        .de      (de),
        .ctrl    (2'b00),
        .din     (pix_g),
        .dout    (enc1)
    );

    tmds_encoder_ch u_ch2 (
        .clk_pix (clk_pix),
        .rstn_i  (rstn_i),
        .de      (de),
        .ctrl    (2'b00),
        .din     (pix_r),
        .dout    (enc2)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            tmds_sym_t out0_r;
            tmds_sym_t out1_r;
            tmds_sym_t out2_r;

            always_ff @(posedge clk_pix) begin
                if (!rstn_i) begin
                    out0_r <= TMDS_CTRL_00;
                    out1_r <= TMDS_CTRL_00;
                    out2_r <= TMDS_CTRL_00;
                end else begin
                    out0_r <= enc0;
                    out1_r <= enc1;
                    out2_r <= enc2;
                end
            end

            assign tmds_ch0 = out0_r;
            assign tmds_ch1 = out1_r;
            assign tmds_ch2 = out2_r;
        end else begin : g_no_out_reg
            assign tmds_ch0 = enc0;
            assign tmds_ch1 = enc1;
            assign tmds_ch2 = enc2;
        end
    endgenerate

endmodule
